// File: rtl/posit_field_decode_pkg.sv
// Shared sizing helpers for the posit decode/encode datapath.
// The posit width N is at most MAX_N. Constants that depend on N are produced by functions.
package posit_pkg;

  localparam int MAX_N = 32;

  // Width of the signed scale: regime magnitude bits, exponent bits, sign bit.
  function automatic int scale_width(input int n, input int es);
    return $clog2(n - 1) + es + 1;
  endfunction

  // Fraction width without the hidden bit. This is the widest fraction any
  // operand can carry: sign, a 1-bit regime, the terminator and ES exponent
  // bits are always consumed.
  function automatic int frac_width(input int n, input int es);
    return n - es - 3;
  endfunction

  // Width needed to hold a regime run length of 1..n-1.
  function automatic int run_width(input int n);
    return $clog2(n);
  endfunction

  // NaR is a 1 in the MSB followed by all zeros. The result is right-aligned in MAX_N bits.
  function automatic logic [MAX_N-1:0] nar_pattern(input int n);
    return {{(MAX_N - 1){1'b0}}, 1'b1} << (n - 1);
  endfunction

endpackage

// File: rtl/posit_field_decode_if.sv
// Operand-in / fields-out handshake bundle for the posit field decoder.
// The decoder uses the slave view. The producer and consumer together use the master view.
interface posit_field_decode_if
  import posit_pkg::*;
#(
  parameter int N  = 32,
  parameter int ES = 2
);

  localparam int SW = scale_width(N, ES);
  localparam int F  = frac_width(N, ES);

  logic          in_valid_i;
  logic          in_ready_o;
  logic [N-1:0]  posit_i;
  logic          out_valid_o;
  logic          out_ready_i;
  logic          sign_o;
  logic [SW-1:0] scale_o;
  logic [F-1:0]  frac_o;
  logic          zero_o;
  logic          nar_o;

  modport slave (
    input  in_valid_i, posit_i, out_ready_i,
    output in_ready_o, out_valid_o, sign_o, scale_o, frac_o, zero_o, nar_o
  );

  modport master (
    output in_valid_i, posit_i, out_ready_i,
    input  in_ready_o, out_valid_o, sign_o, scale_o, frac_o, zero_o, nar_o
  );

endinterface

// File: rtl/posit_field_decode_run_counter.sv
// Leading-run counter for posit regimes. This block is purely combinational.
// It returns the value of the top bit (r0) and the length k of the run of
// bits equal to r0, counted from the MSB downward. A word made of one
// uniform run returns k = W. The future encoder will reuse this block.
module posit_run_counter #(
  parameter int W  = 31,
  parameter int KW = $clog2(W + 1)
) (
  input  logic [W-1:0]  bits_i,
  output logic          r0_o,
  output logic [KW-1:0] k_o
);

  // diff[i] is set where a bit differs from the MSB. The run ends at the highest such bit.
  logic [W-1:0] diff;

  generate
    for (genvar gi = 0; gi < W; gi++) begin : g_diff
      assign diff[gi] = bits_i[gi] ^ bits_i[W-1];
    end
  endgenerate

  assign r0_o = bits_i[W-1];

  // Priority scan from the LSB upward. The highest differing bit is written last, so it wins.
  always_comb begin
    k_o = KW'(W);
    for (int i = 0; i < W; i++) begin
      if (diff[i]) begin
        k_o = KW'(W - 1 - i);
      end
    end
  end

endmodule

// File: rtl/posit_field_decode.sv
// Two-stage posit field decoder.
// Stage 1 captures the sign, the two's-complement magnitude and the zero/NaR flags.
// Stage 2 turns the magnitude into scale and fraction and drives the outputs.
// Each stage holds one operand. Either stage advances when the next stage is
// empty or is being drained in the same cycle.
module posit_field_decode
  import posit_pkg::*;
#(
  parameter int N  = 32,
  parameter int ES = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  posit_field_decode_if.slave bus
);

  localparam int SW = scale_width(N, ES);
  localparam int F  = frac_width(N, ES);
  localparam int KW = run_width(N);
  // Bits left after the regime's first bit and its terminator: exponent followed by fraction.
  localparam int TW = N - 3;

  localparam logic [MAX_N-1:0] NAR_FULL = nar_pattern(N);
  localparam logic [N-1:0]     NAR_PAT  = NAR_FULL[N-1:0];

  // ---------------- handshake ----------------
  logic s1_valid_q, s1_valid_d;
  logic out_valid_q, out_valid_d;
  logic s2_advance;
  logic s1_load;
  logic in_ready;

  // Advance rules. in_ready depends combinationally on out_ready_i, so a full pipe can refill while it drains.
  always_comb begin
    s2_advance = s1_valid_q && (!out_valid_q || bus.out_ready_i);
    in_ready   = !s1_valid_q || s2_advance;
    s1_load    = bus.in_valid_i && in_ready;
  end

  // ---------------- stage 1 ----------------
  // Only abs[N-2:0] is kept. Bit N-1 of the magnitude is set only for NaR,
  // and NaR already has its own flag. The low N-1 bits of -x mod 2^N equal
  // -x[N-2:0] mod 2^(N-1).
  logic             s1_sign_q, s1_sign_d;
  logic [N-2:0]     s1_abs_q,  s1_abs_d;
  logic             s1_zero_q, s1_zero_d;
  logic             s1_nar_q,  s1_nar_d;
  logic [N-2:0]     neg_low;

  assign neg_low = {(N - 1){1'b0}} - bus.posit_i[N-2:0];

  // Capture a new operand on accept. Otherwise hold it, or drop it once it has moved into stage 2.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_sign_d  = s1_sign_q;
    s1_abs_d   = s1_abs_q;
    s1_zero_d  = s1_zero_q;
    s1_nar_d   = s1_nar_q;
    if (s1_load) begin
      s1_valid_d = 1'b1;
      s1_sign_d  = bus.posit_i[N-1];
      s1_abs_d   = bus.posit_i[N-1] ? neg_low : bus.posit_i[N-2:0];
      s1_zero_d  = (bus.posit_i == '0);
      s1_nar_d   = (bus.posit_i == NAR_PAT);
    end else if (s2_advance) begin
      s1_valid_d = 1'b0;
    end
  end

  // ---------------- stage 2 decode ----------------
  logic          r0;
  logic [KW-1:0] k;
  logic [TW-1:0] tail;
  logic [SW-1:0] regime;
  logic [SW-1:0] exp_ext;
  logic [SW-1:0] scale_dec;
  logic [F-1:0]  frac_dec;

  posit_run_counter #(
    .W  (N - 1),
    .KW (KW)
  ) u_run_counter (
    .bits_i (s1_abs_q),
    .r0_o   (r0),
    .k_o    (k)
  );

  // Drop the run and its terminator. Shifting body[N-4:0] left by k-1 equals
  // shifting the full body left by k+1 and keeping the top N-3 bits. Bits
  // shifted in at the bottom are zero, and this supplies the zero padding for
  // a missing exponent or fraction.
  always_comb begin
    tail   = s1_abs_q[N-4:0] << (k - KW'(1));
    regime = r0 ? (SW'(k) - SW'(1)) : (SW'(0) - SW'(k));
  end

  generate
    if (ES > 0) begin : g_exp
      assign exp_ext = SW'(tail[TW-1 -: ES]);
    end else begin : g_no_exp
      assign exp_ext = '0;
    end
  endgenerate

  // The low ES bits of regime << ES are zero, so OR is the same as adding the exponent.
  always_comb begin
    scale_dec = (regime << ES) | exp_ext;
    frac_dec  = tail[F-1:0];
  end

  // ---------------- stage 2 / outputs ----------------
  logic          sign_q,  sign_d;
  logic [SW-1:0] scale_q, scale_d;
  logic [F-1:0]  frac_q,  frac_d;
  logic          zero_q,  zero_d;
  logic          nar_q,   nar_d;

  // Load the decoded fields when stage 1 advances. Otherwise hold, and clear valid once the consumer takes the fields.
  always_comb begin
    out_valid_d = out_valid_q && !bus.out_ready_i;
    sign_d      = sign_q;
    scale_d     = scale_q;
    frac_d      = frac_q;
    zero_d      = zero_q;
    nar_d       = nar_q;
    if (s2_advance) begin
      out_valid_d = 1'b1;
      sign_d      = s1_sign_q;
      zero_d      = s1_zero_q;
      nar_d       = s1_nar_q;
      if (s1_zero_q || s1_nar_q) begin
        scale_d = '0;
        frac_d  = '0;
      end else begin
        scale_d = scale_dec;
        frac_d  = frac_dec;
      end
    end
  end

  // State registers. Reset empties both stages and clears every output field.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_valid_q  <= 1'b0;
      s1_sign_q   <= 1'b0;
      s1_abs_q    <= '0;
      s1_zero_q   <= 1'b0;
      s1_nar_q    <= 1'b0;
      out_valid_q <= 1'b0;
      sign_q      <= 1'b0;
      scale_q     <= '0;
      frac_q      <= '0;
      zero_q      <= 1'b0;
      nar_q       <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_sign_q   <= s1_sign_d;
      s1_abs_q    <= s1_abs_d;
      s1_zero_q   <= s1_zero_d;
      s1_nar_q    <= s1_nar_d;
      out_valid_q <= out_valid_d;
      sign_q      <= sign_d;
      scale_q     <= scale_d;
      frac_q      <= frac_d;
      zero_q      <= zero_d;
      nar_q       <= nar_d;
    end
  end

  assign bus.in_ready_o  = in_ready;
  assign bus.out_valid_o = out_valid_q;
  assign bus.sign_o      = sign_q;
  assign bus.scale_o     = scale_q;
  assign bus.frac_o      = frac_q;
  assign bus.zero_o      = zero_q;
  assign bus.nar_o       = nar_q;

endmodule

// File: tb/tb_posit_field_decode.sv
// Bench for posit_field_decode. It runs two instances: N=32/ES=2 and N=16/ES=1.
// Directed steps use constants worked out by hand. Random traffic is scored
// against a bit-walking reference decoder.
module tb_posit_field_decode;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  posit_field_decode_if #(.N(32), .ES(2)) bus32 ();
  posit_field_decode_if #(.N(16), .ES(1)) bus16 ();

  posit_field_decode #(.N(32), .ES(2)) dut32 (.clk_i(clk), .rst_i(rst), .bus(bus32));
  posit_field_decode #(.N(16), .ES(1)) dut16 (.clk_i(clk), .rst_i(rst), .bus(bus16));

  int checks   = 0;
  int failures = 0;

  // drive values applied by tick()
  bit          d_rst = 1'b1;
  bit          d32_v = 1'b0, d32_r = 1'b1;
  logic [31:0] d32_p = '0;
  bit          d16_v = 1'b0, d16_r = 1'b1;
  logic [15:0] d16_p = '0;

  // values observed by tick() just before the active edge
  bit          seen32_ready, seen32_valid, acc32;
  logic [37:0] seen32_vec;
  bit          seen16_ready, seen16_valid, acc16;
  logic [20:0] seen16_vec;
  int          n_out32 = 0, n_out16 = 0;

  logic [37:0] q32[$];
  logic [20:0] q16[$];

  typedef struct packed {
    logic        sign;
    logic [31:0] scale;
    logic [31:0] frac;
    logic        zero;
    logic        nar;
  } ref_t;

  // Reference decoder. It walks the posit bit by bit, following the field rules.
  function automatic ref_t ref_decode(input logic [31:0] p_in, input int n, input int es);
    ref_t r;
    logic [31:0] mask, p, a;
    int i, k, regime, ex, fw;
    logic r0;
    r    = '0;
    fw   = n - es - 3;
    mask = (n == 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
    p    = p_in & mask;
    if (p == 32'd0) begin
      r.zero = 1'b1;
      return r;
    end
    if (p == (32'd1 << (n - 1))) begin
      r.sign = 1'b1;
      r.nar  = 1'b1;
      return r;
    end
    r.sign = p[n-1];
    a      = r.sign ? (((~p) + 32'd1) & mask) : p;
    i      = n - 2;
    r0     = a[i];
    k      = 0;
    while (i >= 0 && a[i] == r0) begin
      k++;
      i--;
    end
    regime = r0 ? (k - 1) : -k;
    if (i >= 0) i--;  // terminator
    ex = 0;
    for (int e = 0; e < es; e++) begin
      ex = ex * 2 + ((i >= 0) ? int'(a[i]) : 0);
      i--;
    end
    r.scale = 32'(regime * (1 << es) + ex);
    for (int j = 0; j < fw; j++) begin
      r.frac = {r.frac[30:0], (i >= 0) ? a[i] : 1'b0};
      i--;
    end
    return r;
  endfunction

  function automatic logic [37:0] pack32(input ref_t r);
    return {r.sign, r.scale[7:0], r.frac[26:0], r.zero, r.nar};
  endfunction

  function automatic logic [20:0] pack16(input ref_t r);
    return {r.sign, r.scale[5:0], r.frac[11:0], r.zero, r.nar};
  endfunction

  function automatic logic [37:0] pk32(input logic s, input logic [7:0] sc, input logic [26:0] fr,
                                       input logic z, input logic na);
    return {s, sc, fr, z, na};
  endfunction

  function automatic logic [31:0] rnd_posit(input int n);
    logic [31:0] v;
    int sel;
    sel = $urandom_range(0, 15);
    case (sel)
      0:       v = 32'd0;
      1:       v = 32'd1 << (n - 1);
      2:       v = 32'd1;
      3:       v = 32'hFFFF_FFFF;
      4:       v = (32'd1 << (n - 1)) - 32'd1;
      5:       v = (32'd1 << (n - 1)) + 32'd1;
      default: v = $urandom;
    endcase
    return v;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive at the falling edge, sample 1ns later, score outputs, then record accepted operands after the rising edge.
  task automatic tick();
    logic [37:0] o32, e32;
    logic [20:0] o16, e16;
    @(negedge clk);
    rst               = d_rst;
    bus32.in_valid_i  = d32_v;
    bus32.posit_i     = d32_p;
    bus32.out_ready_i = d32_r;
    bus16.in_valid_i  = d16_v;
    bus16.posit_i     = d16_p;
    bus16.out_ready_i = d16_r;
    #1;
    o32 = {bus32.sign_o, bus32.scale_o, bus32.frac_o, bus32.zero_o, bus32.nar_o};
    o16 = {bus16.sign_o, bus16.scale_o, bus16.frac_o, bus16.zero_o, bus16.nar_o};
    seen32_ready = bus32.in_ready_o;
    seen32_valid = bus32.out_valid_o;
    seen32_vec   = o32;
    seen16_ready = bus16.in_ready_o;
    seen16_valid = bus16.out_valid_o;
    seen16_vec   = o16;
    acc32 = !d_rst && d32_v && bus32.in_ready_o;
    acc16 = !d_rst && d16_v && bus16.in_ready_o;
    if (!d_rst && bus32.out_valid_o && d32_r) begin
      n_out32++;
      $display("tx32 out=%h", o32);
      chk("out32_expected_any", 64'(q32.size() != 0), 64'd1);
      if (q32.size() != 0) begin
        e32 = q32.pop_front();
        chk("out32_fields", 64'(o32), 64'(e32));
      end
    end
    if (!d_rst && bus16.out_valid_o && d16_r) begin
      n_out16++;
      $display("tx16 out=%h", o16);
      chk("out16_expected_any", 64'(q16.size() != 0), 64'd1);
      if (q16.size() != 0) begin
        e16 = q16.pop_front();
        chk("out16_fields", 64'(o16), 64'(e16));
      end
    end
    @(posedge clk);
    if (d_rst) begin
      q32.delete();
      q16.delete();
    end else begin
      if (acc32) q32.push_back(pack32(ref_decode(d32_p, 32, 2)));
      if (acc16) q16.push_back(pack16(ref_decode({16'h0, d16_p}, 16, 1)));
    end
  endtask

  logic [31:0] dir_p [9];
  logic [37:0] dir_e [9];
  logic [31:0] bp_ops [4];
  int          idx, base, cnt32, cnt16, cyc;

  initial begin
    dir_p[0] = 32'h4000_0000; dir_e[0] = pk32(1'b0, 8'd0,   27'd0,        1'b0, 1'b0);
    dir_p[1] = 32'hC000_0000; dir_e[1] = pk32(1'b1, 8'd0,   27'd0,        1'b0, 1'b0);
    dir_p[2] = 32'h4400_0000; dir_e[2] = pk32(1'b0, 8'd0,   27'h400_0000, 1'b0, 1'b0);
    dir_p[3] = 32'h4800_0000; dir_e[3] = pk32(1'b0, 8'd1,   27'd0,        1'b0, 1'b0);
    dir_p[4] = 32'h7FFF_FFFF; dir_e[4] = pk32(1'b0, 8'd120, 27'd0,        1'b0, 1'b0);
    dir_p[5] = 32'h0000_0001; dir_e[5] = pk32(1'b0, 8'h88,  27'd0,        1'b0, 1'b0);
    dir_p[6] = 32'h0000_0000; dir_e[6] = pk32(1'b0, 8'd0,   27'd0,        1'b1, 1'b0);
    dir_p[7] = 32'h8000_0000; dir_e[7] = pk32(1'b1, 8'd0,   27'd0,        1'b0, 1'b1);
    dir_p[8] = 32'hFFFF_FFFF; dir_e[8] = pk32(1'b1, 8'h88,  27'd0,        1'b0, 1'b0);
    bp_ops[0] = 32'h4800_0000;
    bp_ops[1] = 32'h4000_0000;
    bp_ops[2] = 32'h4400_0000;
    bp_ops[3] = 32'h7FFF_FFFF;

    // reset state
    tick();
    tick();
    chk("rst_out_valid32", 64'(seen32_valid), 64'd0);
    chk("rst_fields32",    64'(seen32_vec),   64'd0);
    chk("rst_out_valid16", 64'(seen16_valid), 64'd0);
    chk("rst_fields16",    64'(seen16_vec),   64'd0);
    d_rst = 1'b0;
    tick();
    chk("post_rst_in_ready32", 64'(seen32_ready), 64'd1);
    chk("post_rst_in_ready16", 64'(seen16_ready), 64'd1);

    // directed operands: single accept, then check the 2-cycle latency and the fields
    for (int t = 0; t < 9; t++) begin
      d32_v = 1'b1; d32_p = dir_p[t]; d32_r = 1'b1;
      tick();
      chk("dir_accept", 64'(acc32), 64'd1);
      d32_v = 1'b0;
      tick();
      chk("dir_latency_not_early", 64'(seen32_valid), 64'd0);
      tick();
      chk("dir_latency_valid", 64'(seen32_valid), 64'd1);
      chk("dir_fields", 64'(seen32_vec), 64'(dir_e[t]));
      $display("tx32 directed posit=%h fields=%h", dir_p[t], seen32_vec);
    end
    tick();

    // backpressure: consumer stalled while the producer streams 4 operands
    base  = n_out32;
    d32_r = 1'b0; d32_v = 1'b1;
    d32_p = bp_ops[0];
    tick();
    chk("bp_accept0", 64'(acc32), 64'd1);
    d32_p = bp_ops[1];
    tick();
    chk("bp_accept1", 64'(acc32), 64'd1);
    d32_p = bp_ops[2];
    for (int s = 0; s < 3; s++) begin
      tick();
      chk("bp_in_ready_low", 64'(seen32_ready), 64'd0);
      chk("bp_hold_valid",   64'(seen32_valid), 64'd1);
      chk("bp_hold_fields",  64'(seen32_vec),   64'(pk32(1'b0, 8'd1, 27'd0, 1'b0, 1'b0)));
    end
    d32_r = 1'b1;
    idx   = 2;
    for (int c = 0; c < 20; c++) begin
      d32_v = (idx < 4);
      d32_p = bp_ops[idx < 4 ? idx : 3];
      tick();
      if (acc32) idx++;
      if (idx == 4 && q32.size() == 0) break;
    end
    chk("bp_all_accepted", 64'(idx), 64'd4);
    chk("bp_queue_drained", 64'(q32.size()), 64'd0);
    d32_v = 1'b0;
    for (int c = 0; c < 3; c++) tick();
    chk("bp_output_count", 64'(n_out32 - base), 64'd4);

    // reset with two operands in flight
    d32_r = 1'b0; d32_v = 1'b1; d32_p = 32'h4800_0000;
    tick();
    d32_p = 32'h7FFF_FFFF;
    tick();
    d32_v = 1'b0;
    d_rst = 1'b1;
    tick();
    d_rst = 1'b0;
    tick();
    chk("rst_flush_out_valid", 64'(seen32_valid), 64'd0);
    d32_r = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("rst_flush_stays_empty", 64'(seen32_valid), 64'd0);
    end

    // randomized traffic with random stalls on both instances
    cnt32 = 0; cnt16 = 0; cyc = 0;
    while ((cnt32 < 10000 || cnt16 < 10000) && cyc < 60000) begin
      d32_v = (cnt32 < 10000) && ($urandom_range(0, 3) != 0);
      d32_p = rnd_posit(32);
      d32_r = ($urandom_range(0, 9) < 7);
      d16_v = (cnt16 < 10000) && ($urandom_range(0, 3) != 0);
      d16_p = 16'(rnd_posit(16));
      d16_r = ($urandom_range(0, 9) < 7);
      tick();
      if (acc32) cnt32++;
      if (acc16) cnt16++;
      cyc++;
    end
    chk("rand_count32", 64'(cnt32), 64'd10000);
    chk("rand_count16", 64'(cnt16), 64'd10000);
    d32_v = 1'b0; d32_r = 1'b1;
    d16_v = 1'b0; d16_r = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (q32.size() == 0 && q16.size() == 0) break;
    end
    chk("rand_drain32", 64'(q32.size()), 64'd0);
    chk("rand_drain16", 64'(q16.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/posit_field_decode.md
# posit_field_decode

Two-stage pipelined posit field decoder for the PPU: it splits an N-bit posit into sign, combined scale (regime·2^ES + exponent), left-aligned fraction, and zero/NaR flags. It is the inverse of the sign-handling and encode path. It feeds the PPU arithmetic units (add/mul/compare) through a valid/ready handshake at one operand per cycle.

## Interface
- N, default 32: posit width; legal range 8..32.
- ES, default 2: exponent field width; legal range 0..3.
- clk_i  input  1: clock, rising edge.
- rst_i  input  1: reset, synchronous, active-high.
- in_valid_i  input  1: operand valid.
- in_ready_o  output  1: decoder can accept an operand this cycle.
- posit_i  input  N: posit operand.
- out_valid_o  output  1: decoded fields valid.
- out_ready_i  input  1: consumer accepts the fields this cycle.
- sign_o  output  1: sign of the operand.
- scale_o  output  SW = $clog2(N-1)+ES+1: signed scale, two's complement.
- frac_o  output  F = N-ES-3: fraction without the hidden bit, MSB-aligned, zero-padded at the bottom.
- zero_o  output  1: operand is 0.
- nar_o  output  1: operand is NaR (1 followed by all zeros).

## Operation
- Stage 1 (S1) registers the following:
  - sign = posit_i[N-1].
  - abs = sign ? -posit_i : posit_i, computed mod 2^N.
  - zero = posit_i is all zeros.
  - nar = posit_i == 1 followed by N-1 zeros.
- Stage 2 (S2) registers the decode of abs[N-2:0]:
  - r0 = abs[N-2].
  - k = length of the run of bits equal to r0, counted from bit N-2 downward. k ranges 1..N-1.
  - regime = r0 ? k-1 : -k.
  - The run and its terminating bit are skipped. If k = N-1, there is no terminator.
  - The next ES bits are the exponent. Bits missing past the LSB read as 0.
  - All remaining bits form the fraction, MSB-aligned into F bits, zero-padded.
- scale = regime·2^ES + exp, sign-extended to SW bits. For N=32 and ES=2, the range is −120..+120.
- Zero case: sign_o=0, scale_o=0, frac_o=0, zero_o=1.
- NaR case: sign_o=1, scale_o=0, frac_o=0, nar_o=1.
- In both zero and NaR cases the regime decode is ignored.

## Timing
- Reset: out_valid_o=0, sign_o=0, scale_o=0, frac_o=0, zero_o=0, nar_o=0, and both stage-valid flags clear.
- Reset mid-operation discards all in-flight operands. in_ready_o=1 in the first cycle after reset deasserts.
- Latency: exactly 2 cycles from an accepted input (in_valid_i && in_ready_o) to out_valid_o, when there is no backpressure.
- Throughput: 1 operand per cycle while out_ready_i=1.
- Stage advance rules:
  - S2 loads when S1 is valid and (S2 is empty or out_ready_i).
  - S1 loads when in_valid_i and (S1 is empty or S1 is advancing).
- in_ready_o = !s1_valid || s1_advance. It has a combinational path from out_ready_i; this is allowed.
- While out_valid_o && !out_ready_i, every output holds stable and the pipeline stalls. At most 2 operands are buffered.
- Simultaneous accept and consume when full: S2 takes S1's contents and S1 takes the new operand in the same cycle, with no bubble.
- Inputs are sampled only on accept. posit_i is don't-care otherwise.

## Structure
- posit_pkg holds:
  - function scale_width(N, ES) and frac_width(N, ES).
  - The NaR pattern constant, generated from N.
- Sub-module posit_run_counter (combinational) takes abs[N-2:0] and returns k and r0. It is a reusable leading-run/LZC, also needed by the future encoder.
- The top-level module holds both pipeline stages and the handshake logic.

## Test plan
Unless stated otherwise, N=32 and ES=2.
- 0x40000000 -> sign 0, scale 0, frac 0, after 2 cycles.
- 0xC0000000 -> sign 1, scale 0, frac 0.
- 0x44000000 -> scale 0, frac 0x4000000. 0x48000000 -> scale 1, frac 0.
- Boundary values:
  - 0x7FFFFFFF -> scale +120, frac 0.
  - 0x00000001 -> scale −120.
  - 0x00000000 -> zero_o=1.
  - 0x80000000 -> nar_o=1, sign 1.
- Backpressure:
  - Stream of 4 operands with out_ready_i low for 3 cycles -> in_ready_o drops after 2 accepts, outputs hold stable, and the order is preserved with no loss or duplication.
  - Reset asserted with 2 in flight -> out_valid_o=0 on the next cycle, and the old operands never appear.
- Randomized: 10k random posits, with N=16, ES=1 and N=32, ES=2, with random ready stalls -> fields match a reference decoder model.
